// File: rtl/paadd_pipe.sv
// Pipelined WIDTH-bit adder computing {c,s} = a + b + ci, one CHUNK-bit ripple slice per stage.
// Valid/ready streaming with carry out and signed-overflow flag; one add accepted per cycle.
module paadd_pipe #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c,
   output logic             ovf
);
   localparam int STAGES = WIDTH / CHUNK;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_cfg
         $error("paadd_pipe: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // Every stage moves together on adv; a stalled output freezes the whole pipe, bubbles included.
   logic adv;

   logic [STAGES-1:0] v_q;
   logic [WIDTH-1:0]  a_q  [STAGES];
   logic [WIDTH-1:0]  b_q  [STAGES];
   logic [WIDTH-1:0]  s_q  [STAGES];
   logic              cy_q [STAGES];
   logic              ovf_q;

   logic [STAGES-1:0] v_in;
   logic [WIDTH-1:0]  a_in  [STAGES];
   logic [WIDTH-1:0]  b_in  [STAGES];
   logic [WIDTH-1:0]  s_in  [STAGES];
   logic [WIDTH-1:0]  s_nx  [STAGES];
   logic              cy_in [STAGES];
   logic              cy_nx [STAGES];
   logic [CHUNK:0]    slice;
   logic              ovf_nx;

   assign adv      = !v_q[STAGES-1] | out_ready;
   assign in_ready = adv;

   always_comb begin
      v_in[0]  = in_valid;
      a_in[0]  = a;
      b_in[0]  = b;
      s_in[0]  = '0;
      cy_in[0] = ci;
      for (int k = 1; k < STAGES; k++) begin
         v_in[k]  = v_q[k-1];
         a_in[k]  = a_q[k-1];
         b_in[k]  = b_q[k-1];
         s_in[k]  = s_q[k-1];
         cy_in[k] = cy_q[k-1];
      end
      slice  = '0;
      ovf_nx = 1'b0;
      // Stage k fills slice k of the sum; lower slices ride along unchanged.
      for (int k = 0; k < STAGES; k++) begin
         slice = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, cy_in[k]};
         s_nx[k] = s_in[k];
         s_nx[k][k*CHUNK +: CHUNK] = slice[CHUNK-1:0];
         cy_nx[k] = slice[CHUNK];
      end
      // After the loop slice holds the top slice; recover the carry into the MSB from its sum bit.
      ovf_nx = (slice[CHUNK-1] ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]) ^ slice[CHUNK];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         v_q   <= '0;
         ovf_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            s_q[k]  <= '0;
            cy_q[k] <= 1'b0;
         end
      end else if (adv) begin
         v_q <= v_in;
         for (int k = 0; k < STAGES; k++) begin
            if (v_in[k]) begin
               a_q[k]  <= a_in[k];
               b_q[k]  <= b_in[k];
               s_q[k]  <= s_nx[k];
               cy_q[k] <= cy_nx[k];
            end
         end
         if (v_in[STAGES-1]) begin
            ovf_q <= ovf_nx;
         end
      end
   end

   assign out_valid = v_q[STAGES-1];
   assign s         = s_q[STAGES-1];
   assign c         = cy_q[STAGES-1];
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_paadd_pipe.sv
// Bench for paadd_pipe: a WIDTH=4/CHUNK=1 and a default WIDTH=8/CHUNK=2 instance share one
// stimulus driver; results are scored against an arithmetic reference model.
module tb_paadd_pipe;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] a_i = '0;
   logic [7:0] b_i = '0;
   logic       ci_i = 1'b0;
   logic       out_ready = 1'b1;
   logic       sel8 = 1'b0;

   logic       rdy4, ov4, c4, ovf4;
   logic [3:0] s4;
   logic       rdy8, ov8, c8, ovf8;
   logic [7:0] s8;

   logic       obs_ready, obs_valid, obs_c, obs_ovf;
   logic [7:0] obs_s;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   logic [9:0] exp_q[$];
   int         acc_q[$];
   logic       vlog[$];
   logic       strict = 1'b0;
   logic       hold_pend = 1'b0;
   logic       rst_prev = 1'b0;
   logic       last_acc = 1'b0;
   logic [7:0] hold_s;
   logic       hold_c, hold_ovf;

   always #5 clk = ~clk;

   paadd_pipe #(.WIDTH(4), .CHUNK(1)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & !sel8), .in_ready(rdy4),
      .a(a_i[3:0]), .b(b_i[3:0]), .ci(ci_i), .out_valid(ov4), .out_ready(out_ready | sel8),
      .s(s4), .c(c4), .ovf(ovf4)
   );

   paadd_pipe #(.WIDTH(8), .CHUNK(2)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel8), .in_ready(rdy8),
      .a(a_i), .b(b_i), .ci(ci_i), .out_valid(ov8), .out_ready(out_ready | !sel8),
      .s(s8), .c(c8), .ovf(ovf8)
   );

   assign obs_ready = sel8 ? rdy8 : rdy4;
   assign obs_valid = sel8 ? ov8 : ov4;
   assign obs_s     = sel8 ? s8 : {4'b0000, s4};
   assign obs_c     = sel8 ? c8 : c4;
   assign obs_ovf   = sel8 ? ovf8 : ovf4;

   function automatic int cur_w();
      return sel8 ? 8 : 4;
   endfunction

   function automatic int cur_stages();
      return sel8 ? 8 / 2 : 4 / 1;
   endfunction

   // Reference: unsigned sum for s/c, signed sum range test for ovf.
   function automatic logic [9:0] ref_add(input int w, input logic [7:0] ra, input logic [7:0] rb,
                                          input logic rci);
      int ua, ub, full, sa, sb, ss;
      logic [7:0] rs;
      logic rc, ro;
      ua   = int'(ra);
      ub   = int'(rb);
      full = ua + ub + int'(rci);
      sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
      sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
      ss   = sa + sb + int'(rci);
      rs   = 8'(full % (1 << w));
      rc   = (full >= (1 << w));
      ro   = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
      return {ro, rc, rs};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d, width %0d)", tag, got, exp, cyc, cur_w());
      end
   endtask

   // One clock: drive at negedge, observe settled outputs, score handshakes of the coming edge.
   task automatic step(input logic iv, input logic [7:0] ia, input logic [7:0] ib, input logic ici,
                       input logic ordy, input logic rst);
      logic [9:0] e;
      int t_acc;
      @(negedge clk);
      rst_n     = !rst;
      in_valid  = iv;
      a_i       = ia;
      b_i       = ib;
      ci_i      = ici;
      out_ready = ordy;
      #1;
      last_acc = 1'b0;
      vlog.push_back(obs_valid);
      if (rst_prev) begin
         check("rst_valid", obs_valid, 0);
         check("rst_s", obs_s, 0);
         check("rst_c", obs_c, 0);
         check("rst_ovf", obs_ovf, 0);
      end
      if (hold_pend) begin
         check("hold_valid", obs_valid, 1);
         check("hold_s", obs_s, hold_s);
         check("hold_c", obs_c, hold_c);
         check("hold_ovf", obs_ovf, hold_ovf);
      end
      check("in_ready", obs_ready, !obs_valid || ordy);
      if (rst) begin
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (obs_valid && ordy) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", obs_valid, 0);
            end else begin
               e = exp_q.pop_front();
               t_acc = acc_q.pop_front();
               check("sum", obs_s, e[7:0]);
               check("carry", obs_c, e[8]);
               check("ovf", obs_ovf, e[9]);
               if (strict) check("latency", cyc - t_acc, cur_stages());
            end
         end
         if (iv && obs_ready) begin
            exp_q.push_back(ref_add(cur_w(), ia, ib, ici));
            acc_q.push_back(cyc);
            last_acc = 1'b1;
         end
      end
      hold_pend = obs_valid && !ordy && !rst;
      hold_s    = obs_s;
      hold_c    = obs_c;
      hold_ovf  = obs_ovf;
      rst_prev  = rst;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(1);
   endtask

   task automatic drain();
      idle(12);
      check("drain_empty", exp_q.size(), 0);
   endtask

   task automatic random_run(input int n);
      logic [7:0] mask, ra, rb;
      logic iv, ordy, rst;
      mask = (cur_w() == 8) ? 8'hFF : 8'h0F;
      for (int i = 0; i < n; i++) begin
         iv   = ($urandom_range(0, 9) < 6);
         ordy = ($urandom_range(0, 9) < 7);
         rst  = ($urandom_range(0, 999) == 0);
         ra   = 8'($urandom_range(0, 255)) & mask;
         rb   = 8'($urandom_range(0, 255)) & mask;
         if ($urandom_range(0, 7) == 0) ra = mask;
         if ($urandom_range(0, 7) == 0) rb = mask;
         step(iv, ra, rb, 1'($urandom_range(0, 1)), ordy, rst);
      end
   endtask

   initial begin
      logic [7:0] da[6], db[6];
      logic       dc[6];
      logic [7:0] oa[3], ob[3];
      logic [7:0] ta[9], tb[9];
      logic       tc[9];
      logic       pat[4];
      int c0, sent;

      da = '{8'h0, 8'h5, 8'hA, 8'h5, 8'hF, 8'hF};
      db = '{8'h0, 8'h5, 8'hA, 8'h5, 8'hF, 8'hF};
      dc = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      oa = '{8'h7, 8'h8, 8'hF};
      ob = '{8'h1, 8'h8, 8'h1};
      ta = '{8'hFF, 8'h01, 8'h80, 8'h7F, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'h00};
      tb = '{8'h01, 8'hFF, 8'h80, 8'h01, 8'h55, 8'hAB, 8'h00, 8'hFF, 8'h00};
      tc = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      pat = '{1'b1, 1'b0, 1'b1, 1'b0};

      // WIDTH=4, CHUNK=1
      sel8 = 1'b0;
      do_reset();
      strict = 1'b1;
      for (int i = 0; i < 6; i++) step(1'b1, da[i], db[i], dc[i], 1'b1, 1'b0);
      idle(6);
      for (int i = 0; i < 3; i++) step(1'b1, oa[i], ob[i], 1'b0, 1'b1, 1'b0);
      idle(6);
      strict = 1'b0;
      random_run(2000);
      drain();

      // WIDTH=8, CHUNK=2
      sel8 = 1'b1;
      do_reset();
      strict = 1'b1;
      c0 = cyc;
      for (int i = 0; i < 4; i++) step(pat[i], 8'(i * 37), 8'(i * 91), 1'b0, 1'b1, 1'b0);
      idle(6);
      for (int i = 0; i < 4; i++) check("bubble_valid", vlog[c0 + 4 + i], pat[i]);
      strict = 1'b0;

      sent = 0;
      for (int t = 0; t < 40 && sent < 8; t++) begin
         step(1'b1, ta[sent], tb[sent], tc[sent], !(t >= 5 && t < 10), 1'b0);
         if (last_acc) sent++;
      end
      check("stall_sent", sent, 8);
      drain();

      strict = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, ta[i], tb[i], tc[i], 1'b1, 1'b0);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
      idle(6);
      step(1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
      idle(6);
      check("post_rst_empty", exp_q.size(), 0);
      strict = 1'b0;

      random_run(10000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
